div_iterative: RTL
==================

# div_iterative

Iterative restoring divider that sits behind the EX-stage ALU and answers its `div_begin`/`div_done` request for DIV and DIVU. It takes pre-conditioned operands from the ALU: unsigned magnitudes plus two sign flags. It runs one quotient bit per cycle and returns a sign-corrected quotient and remainder. The ALU places `{div_remainder, div_quotient}` on `hilo` during the cycle in which `div_done` is high.

## Interface

Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `div_begin`  in  1  request level, held high by the ALU while a divide sits in EX.
- `div_sign`  in  1  negate the quotient at completion.
- `div_dividend_sign`  in  1  negate the remainder at completion.
- `div_dividend`  in  WIDTH  dividend magnitude.
- `div_divisor`  in  WIDTH  divisor magnitude.
- `div_quotient`  out  WIDTH  sign-corrected quotient.
- `div_remainder`  out  WIDTH  sign-corrected remainder.
- `div_done`  out  1  result-valid strobe, one cycle.
- `div_busy`  out  1  high while in BUSY.

## Operation

States:
- IDLE:
  - `div_begin`=1 at the edge → capture the dividend, divisor and both sign flags; clear the partial remainder and counter; go to BUSY.
  - `div_begin`=0 → stay in IDLE.
- BUSY, one step per edge:
  - partial remainder P = {P[WIDTH-2:0], Q[WIDTH-1]}; Q shifts left.
  - If P ≥ divisor: P = P − divisor and new Q bit = 1; otherwise the new Q bit = 0.
  - The counter increments. The edge that performs step WIDTH moves to DONE.
- DONE: `div_done`=1 for this cycle only. The next edge goes to IDLE unconditionally.

Rules:
- Arithmetic: the compare and subtract use WIDTH+1 bits, so no overflow is possible.
- Sign correction is applied at the outputs only:
  - `div_quotient` = `div_sign` ? −Q : Q.
  - `div_remainder` = `div_dividend_sign` ? −P : P.
  - Negation is two's complement, modulo 2^WIDTH.
- Operand inputs are ignored outside the capture edge; changes during BUSY have no effect.
- Abort: `div_begin` low at any BUSY edge → go to IDLE and discard the result; `div_done` is never raised for that request.
- A divisor of zero needs no special case. The natural result is Q = all ones and P = the dividend magnitude, with signs then applied. The ALU raises the exception itself.
- `div_begin` is ignored during DONE. It is sampled again in IDLE, so a back-to-back divide starts on the edge after DONE.
- Outputs hold their last result until the next capture edge. At a capture edge the working registers clear.

## Timing

- Reset values, asynchronous: state IDLE; `div_done`=0; `div_busy`=0; `div_quotient`=0; `div_remainder`=0; counter=0.
- Latency: request first high in cycle 0 → capture at the end of cycle 0 → BUSY during cycles 1..WIDTH → `div_done` and valid results in cycle WIDTH+1 (cycle 33 at WIDTH=32).
- Minimum spacing between back-to-back requests: WIDTH+2 cycles.
- `rst` asserted mid-operation returns the block to IDLE immediately with all outputs at their reset values.

## Configuration

- `DIV_EARLY_OUT_EN` defined:
  - At the capture edge, if divisor == 0 or dividend < divisor, go straight to DONE with the final Q/P loaded directly.
  - Divisor 0: Q = all ones, P = dividend.
  - Dividend < divisor: Q = 0, P = dividend.
  - `div_done` is then high in cycle 1.
- Not defined: every request takes the full WIDTH+1 cycle latency.
- Results are bit-identical either way; only the latency differs.

## Test plan

- Unsigned: dividend 100, divisor 7, both signs 0 → quotient 14, remainder 2, `div_done` in cycle 33, high for exactly one cycle.
- Signed: −7/2, driven as dividend 7, divisor 2, `div_sign`=1, `div_dividend_sign`=1 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Divide by zero: 0x12345678/0 → quotient 0xFFFFFFFF, remainder 0x12345678; `div_done` in cycle 1 with `DIV_EARLY_OUT_EN`, cycle 33 without.
- Abort: drop `div_begin` in cycle 10 → `div_done` never rises and `div_busy` falls. A new request 50/5 then returns 10 and 0.
- Back-to-back: hold `div_begin` through DONE with new operands 0xFFFFFFFF/0x10 → second result 0x0FFFFFFF remainder 0xF, `div_done` 34 cycles after the first.
- Reset at cycle 20 of an operation → all outputs 0 and IDLE; operands changed during BUSY do not affect the result.

Source files
------------

// File: rtl/div_iterative.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_iterative                                                            |
// | Restoring divider, one quotient bit per cycle, sign-corrected outputs.   |
// | Optional feature macro: DIV_EARLY_OUT_EN (divisor 0 / dividend<divisor). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_begin,
    input  logic             div_sign,
    input  logic             div_dividend_sign,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_done,
    output logic             div_busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0]    c_st_idle = 2'd0;
    localparam logic [1:0]    c_st_busy = 2'd1;
    localparam logic [1:0]    c_st_done = 2'd2;
    localparam logic [CW-1:0] c_last    = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_divisor;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic             w_early;

    // The compare runs on WIDTH+1 bits; when it succeeds the difference is
    // below the divisor, so a WIDTH-bit subtract is exact.
    assign w_shift = {r_p, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    assign w_sub   = w_shift[WIDTH-1:0] - r_divisor;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (div_divisor == '0) || (div_dividend < div_divisor);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (div_begin) begin
                    w_next_state = w_early ? c_st_done : c_st_busy;
                end
            end
            c_st_busy: begin
                if (!div_begin) begin
                    w_next_state = c_st_idle;
                end else if (r_count == c_last) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_p       <= '0;
            r_divisor <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (div_begin) begin
                        r_divisor <= div_divisor;
                        r_sign_q  <= div_sign;
                        r_sign_r  <= div_dividend_sign;
                        r_count   <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (w_early) begin
                            r_q <= (div_divisor == '0) ? '1 : '0;
                            r_p <= div_dividend;
                        end else begin
                            r_q <= div_dividend;
                            r_p <= '0;
                        end
`else
                        r_q <= div_dividend;
                        r_p <= '0;
`endif
                    end
                end
                c_st_busy: begin
                    if (div_begin) begin
                        r_p     <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                        r_q     <= {r_q[WIDTH-2:0], w_ge};
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_quotient  = r_sign_q ? -r_q : r_q;
    assign div_remainder = r_sign_r ? -r_p : r_p;
    assign div_done      = (r_state == c_st_done);
    assign div_busy      = (r_state == c_st_busy);

endmodule
`default_nettype wire
